// File: rtl/bit_parity_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bit_parity_monitor
// Description : Framed serial bit-stream monitor. It keeps ones/zeros counts,
//               parity flags and the longest ones-run, then latches a summary
//               at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_parity_monitor #(
    parameter int CNT_W  = 8,
    parameter bit RUN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             even1,
    output logic             even0,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] zeros_cnt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_ones,
    output logic [CNT_W-1:0] frame_zeros,
    output logic             frame_even1,
    output logic             frame_even0,
    output logic [CNT_W-1:0] frame_maxrun,
    output logic             frame_ovf
);

    localparam logic [CNT_W-1:0] c_max = '1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             w_accept;
    logic             w_end;

    logic [CNT_W-1:0] r_ones, r_zeros;
    logic             r_even1, r_even0, r_ovf;
    logic [CNT_W-1:0] w_ones_nxt, w_zeros_nxt;
    logic             w_even1_nxt, w_even0_nxt, w_ovf_nxt;
    logic [CNT_W-1:0] w_maxrun_nxt;

    logic [CNT_W-1:0] r_frame_ones, r_frame_zeros, r_frame_maxrun;
    logic             r_frame_even1, r_frame_even0, r_frame_ovf;
    logic             r_done;

    // clear wins over in_valid, so a bit presented with clear is dropped.
    assign w_accept = in_valid && !clear;
    assign w_end    = w_accept && in_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else if (in_valid) begin
            w_state_nxt = in_last ? IDLE : ACTIVE;
        end
    end

    always_comb begin
        w_ones_nxt  = r_ones;
        w_zeros_nxt = r_zeros;
        w_even1_nxt = r_even1;
        w_even0_nxt = r_even0;
        w_ovf_nxt   = r_ovf;
        if (w_accept) begin
            // Parity toggles even when its counter is pinned at saturation.
            if (in_bit) begin
                w_even1_nxt = ~r_even1;
                if (r_ones == c_max) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_ones_nxt = r_ones + 1'b1;
                end
            end else begin
                w_even0_nxt = ~r_even0;
                if (r_zeros == c_max) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_zeros_nxt = r_zeros + 1'b1;
                end
            end
        end
    end

    generate
        if (RUN_EN) begin : g_run
            logic [CNT_W-1:0] r_run_cur, r_run_max;
            logic [CNT_W-1:0] w_run_inc, w_run_cur_nxt, w_run_max_nxt;

            assign w_run_inc = (r_run_cur == c_max) ? c_max : r_run_cur + 1'b1;

            always_comb begin
                w_run_cur_nxt = r_run_cur;
                w_run_max_nxt = r_run_max;
                if (w_accept) begin
                    if (in_bit) begin
                        w_run_cur_nxt = w_run_inc;
                        if (w_run_inc > r_run_max) begin
                            w_run_max_nxt = w_run_inc;
                        end
                    end else begin
                        w_run_cur_nxt = '0;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_run_cur <= '0;
                    r_run_max <= '0;
                end else if (clear || w_end) begin
                    r_run_cur <= '0;
                    r_run_max <= '0;
                end else begin
                    r_run_cur <= w_run_cur_nxt;
                    r_run_max <= w_run_max_nxt;
                end
            end

            assign w_maxrun_nxt = w_run_max_nxt;
        end else begin : g_no_run
            assign w_maxrun_nxt = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ones         <= '0;
            r_zeros        <= '0;
            r_even1        <= 1'b1;
            r_even0        <= 1'b1;
            r_ovf          <= 1'b0;
            r_done         <= 1'b0;
            r_frame_ones   <= '0;
            r_frame_zeros  <= '0;
            r_frame_even1  <= 1'b1;
            r_frame_even0  <= 1'b1;
            r_frame_maxrun <= '0;
            r_frame_ovf    <= 1'b0;
        end else begin
            r_done <= w_end;
            // Running state restarts in the same update as frame end, so a new
            // frame may begin on the very next cycle.
            if (clear || w_end) begin
                r_ones  <= '0;
                r_zeros <= '0;
                r_even1 <= 1'b1;
                r_even0 <= 1'b1;
                r_ovf   <= 1'b0;
            end else begin
                r_ones  <= w_ones_nxt;
                r_zeros <= w_zeros_nxt;
                r_even1 <= w_even1_nxt;
                r_even0 <= w_even0_nxt;
                r_ovf   <= w_ovf_nxt;
            end
            if (w_end) begin
                r_frame_ones   <= w_ones_nxt;
                r_frame_zeros  <= w_zeros_nxt;
                r_frame_even1  <= w_even1_nxt;
                r_frame_even0  <= w_even0_nxt;
                r_frame_maxrun <= w_maxrun_nxt;
                r_frame_ovf    <= w_ovf_nxt;
            end
        end
    end

    assign even1        = r_even1;
    assign even0        = r_even0;
    assign ones_cnt     = r_ones;
    assign zeros_cnt    = r_zeros;
    assign busy         = (r_state == ACTIVE);
    assign done         = r_done;
    assign frame_ones   = r_frame_ones;
    assign frame_zeros  = r_frame_zeros;
    assign frame_even1  = r_frame_even1;
    assign frame_even0  = r_frame_even0;
    assign frame_maxrun = r_frame_maxrun;
    assign frame_ovf    = r_frame_ovf;

endmodule
`default_nettype wire
